icache_refill: RTL
==================

# icache_refill

Refill engine sitting directly upstream of the instruction cache. When the cache reports a miss, it requests the shared byte-wide RAM bus from the memory arbiter and issues 16 sequential byte reads for the missing line. It assembles the bytes into a 128-bit line and presents it to the cache with a one-cycle fill strobe.

## Interface
- ADDR_WIDTH, 17, byte address width
- BLOCK_WIDTH, 4, log2 of line size in bytes
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes (16)

Ports:
- clkIn  in  1  system clock
- resetIn  in  1  asynchronous, active-low reset
- missIn  in  1  cache miss flag, meaningful only while instrValidIn is high
- instrValidIn  in  1  fetch address valid
- missAddrIn  in  ADDR_WIDTH  fetch address that missed
- flushIn  in  1  abandon current refill (pipeline redirect)
- grantIn  in  1  arbiter grant of RAM bus
- ramDataIn  in  8  RAM read data; one-cycle latency after ramAddrOut
- reqOut  out  1  RAM bus request
- ramAddrOut  out  ADDR_WIDTH  RAM byte read address, registered
- memDataValid  out  1  line fill strobe to cache
- memAddr  out  ADDR_WIDTH-BLOCK_WIDTH  line address of filled line
- memDataOut  out  BLOCK_SIZE*8  assembled line, little-endian
- busyOut  out  1  refill in progress (state != IDLE)

## Operation
- FSM states are IDLE, REQ, READ, DONE.
- IDLE: if instrValidIn && missIn && !flushIn, latch lineAddr = missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH] and go to REQ. Otherwise stay.
- REQ: reqOut=1. On grantIn=1, clear issueCnt/recvCnt and go to READ. On flushIn, go to IDLE.
- READ: each cycle, drive ramAddrOut = {lineAddr, issueCnt} while issueCnt < 16, then increment issueCnt. Each cycle after the first, capture ramDataIn into byte slot recvCnt, i.e. bits [8k+7:8k] for byte k, then increment recvCnt. When byte 15 is captured, go to DONE.
- DONE: memDataValid=1 for exactly one cycle, memAddr=lineAddr, reqOut=0. Next state is IDLE.
- flushIn in READ aborts immediately. Next state is IDLE, reqOut drops, and no fill occurs. flushIn in DONE is ignored: the fill still happens, since filling is harmless.
- missIn while not IDLE is ignored. missAddrIn changes are not tracked mid-refill.
- Arbiter contract: grantIn stays high while reqOut is high after first grant. A drop mid-READ is a protocol violation and is not handled.
- Line address arithmetic is pure concatenation, so there is no carry. Top line 0x1FFF reads 0x1FFF0–0x1FFFF.
- Reset mid-operation forces IDLE asynchronously. The partial line is discarded.

## Timing
- Reset values: reqOut 0, ramAddrOut 0, memDataValid 0, memAddr 0, memDataOut 0, busyOut 0. Internal state is IDLE and all counters are 0.
- Miss sampled in IDLE at edge t, so reqOut=1 from cycle t+1.
- grantIn high in cycle g (in REQ) means ramAddrOut = byte 0 in cycle g+1 and byte k in cycle g+1+k.
- Byte k data is valid in cycle g+2+k. Byte 15 is captured at the end of cycle g+17.
- memDataValid is high in cycle g+18. reqOut is low from cycle g+18.
- With grant on the first REQ cycle, miss-to-fill latency is 19 cycles. The cache hits in cycle g+19.
- memDataOut holds its value after DONE until the next capture.

## Configuration
- ICACHE_REFILL_STATS_EN defined: adds outputs refillCountOut[31:0] and stallCycleOut[31:0].
  - refillCountOut increments on each memDataValid.
  - stallCycleOut increments every cycle busyOut=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: those ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package holds the state encoding (IDLE/REQ/READ/DONE), the BLOCK_SIZE/BLOCK_WIDTH constants, and the 8-bit RAM data width.
- One sub-module, refill_line_buffer: byte-slot register file with write enable, slot index and clear. It outputs the full line.

## Test plan
- Miss at 0x00104, grant immediate, RAM returns byte = addr[7:0]:
  - ramAddrOut runs 0x00100..0x0010F on consecutive cycles.
  - memDataValid is high for one cycle with memAddr 0x0010 and memDataOut 0x0F0E0D0C_0B0A0908_07060504_03020100.
- Grant delayed 5 cycles: reqOut is held and ramAddrOut is static. All later events shift by exactly 5 cycles, and the line matches the first scenario.
- flushIn while byte 7 is being issued:
  - reqOut is 0 the next cycle, no memDataValid occurs, and busyOut falls.
  - A new miss at 0x00200 one cycle later starts a fresh refill at 0x00200.
- resetIn low mid-READ: all outputs are 0 immediately, without a clock. After release with missIn low, the block stays IDLE.
- Miss at 0x1FFF8: addresses run 0x1FFF0..0x1FFFF and memAddr is 0x1FFF, with no overflow. A back-to-back miss on 0x00000 after DONE starts on the following IDLE cycle.
- With ICACHE_REFILL_STATS_EN, two completed refills with immediate grant: refillCountOut is 2 and stallCycleOut is 38.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared constants for the instruction-cache refill engine: line geometry,
// RAM data width and FSM state encoding.
package icache_refill_pkg;

  localparam int unsigned ADDR_WIDTH  = 17;
  localparam int unsigned BLOCK_WIDTH = 4;
  localparam int unsigned BLOCK_SIZE  = 2 ** BLOCK_WIDTH;
  localparam int unsigned RAM_DW      = 8;
  localparam int unsigned LINE_W      = BLOCK_SIZE * RAM_DW;
  localparam int unsigned LINE_AW     = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int unsigned CNT_W       = BLOCK_WIDTH + 1;
  localparam int unsigned STAT_W      = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/icache_refill_if.sv
// Cache-side and RAM-bus signals of the refill engine.
// ICACHE_REFILL_STATS_EN adds the refillCountOut/stallCycleOut counters.
interface icache_refill_if;
  import icache_refill_pkg::*;

  logic                  missIn;
  logic                  instrValidIn;
  logic [ADDR_WIDTH-1:0] missAddrIn;
  logic                  flushIn;
  logic                  grantIn;
  logic [RAM_DW-1:0]     ramDataIn;
  logic                  reqOut;
  logic [ADDR_WIDTH-1:0] ramAddrOut;
  logic                  memDataValid;
  logic [LINE_AW-1:0]    memAddr;
  logic [LINE_W-1:0]     memDataOut;
  logic                  busyOut;
`ifdef ICACHE_REFILL_STATS_EN
  logic [STAT_W-1:0]     refillCountOut;
  logic [STAT_W-1:0]     stallCycleOut;

  modport master (
    input  missIn, instrValidIn, missAddrIn, flushIn, grantIn, ramDataIn,
    output reqOut, ramAddrOut, memDataValid, memAddr, memDataOut, busyOut,
    output refillCountOut, stallCycleOut
  );
  modport slave (
    output missIn, instrValidIn, missAddrIn, flushIn, grantIn, ramDataIn,
    input  reqOut, ramAddrOut, memDataValid, memAddr, memDataOut, busyOut,
    input  refillCountOut, stallCycleOut
  );
`else
  modport master (
    input  missIn, instrValidIn, missAddrIn, flushIn, grantIn, ramDataIn,
    output reqOut, ramAddrOut, memDataValid, memAddr, memDataOut, busyOut
  );
  modport slave (
    output missIn, instrValidIn, missAddrIn, flushIn, grantIn, ramDataIn,
    input  reqOut, ramAddrOut, memDataValid, memAddr, memDataOut, busyOut
  );
`endif

endinterface

// File: rtl/refill_line_buffer.sv
// Byte-slot register file that assembles a cache line, little-endian
// (slot k occupies bits [8k+7:8k]).
module refill_line_buffer
  import icache_refill_pkg::*;
(
  input  logic                   clkIn,
  input  logic                   resetIn,
  input  logic                   we_i,
  input  logic                   clr_i,
  input  logic [BLOCK_WIDTH-1:0] slot_i,
  input  logic [RAM_DW-1:0]      din_i,
  output logic [LINE_W-1:0]      line_o
);

  logic [BLOCK_SIZE-1:0][RAM_DW-1:0] slot_q;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      slot_q <= '0;
    end else if (clr_i) begin
      slot_q <= '0;
    end else if (we_i) begin
      slot_q[slot_i] <= din_i;
    end
  end

  assign line_o = slot_q;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches a 16-byte line over the byte-wide
// RAM bus and fills the cache. ICACHE_REFILL_STATS_EN adds refill/stall counters.
module icache_refill
  import icache_refill_pkg::*;
(
  input  logic           clkIn,
  input  logic           resetIn,
  icache_refill_if.master bus
);

  logic [1:0]             state_q, state_d;
  logic [LINE_AW-1:0]     line_q, line_d;
  logic [CNT_W-1:0]       issue_q, issue_d;
  logic [BLOCK_WIDTH-1:0] recv_q, recv_d;
  logic                   first_q, first_d;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [LINE_AW-1:0]     mem_addr_q, mem_addr_d;
  logic                   req_q, busy_q, valid_q;
  logic                   cap_en_c;
  logic                   unused_offset_c;

  // Byte offset of the missing address is irrelevant: the whole line is fetched.
  assign unused_offset_c = ^bus.missAddrIn[BLOCK_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    issue_d    = issue_q;
    recv_d     = recv_q;
    first_d    = first_q;
    ram_addr_d = ram_addr_q;
    mem_addr_d = mem_addr_q;
    cap_en_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instrValidIn && bus.missIn && !bus.flushIn) begin
          line_d  = bus.missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.flushIn) begin
          state_d = S_IDLE;
        end else if (bus.grantIn) begin
          // Byte 0 address is launched on the grant edge; issue count starts at 1.
          ram_addr_d = {line_q, BLOCK_WIDTH'(0)};
          issue_d    = CNT_W'(1);
          recv_d     = '0;
          first_d    = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        if (bus.flushIn) begin
          state_d = S_IDLE;
        end else begin
          first_d = 1'b0;
          if (issue_q < CNT_W'(BLOCK_SIZE)) begin
            ram_addr_d = {line_q, issue_q[BLOCK_WIDTH-1:0]};
            issue_d    = issue_q + CNT_W'(1);
          end
          // RAM data trails the address by one cycle, so skip the first READ cycle.
          if (!first_q) begin
            cap_en_c = 1'b1;
            recv_d   = recv_q + BLOCK_WIDTH'(1);
            if (recv_q == BLOCK_WIDTH'(BLOCK_SIZE - 1)) begin
              mem_addr_d = line_q;
              state_d    = S_DONE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      issue_q    <= '0;
      recv_q     <= '0;
      first_q    <= 1'b0;
      ram_addr_q <= '0;
      mem_addr_q <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      first_q    <= first_d;
      ram_addr_q <= ram_addr_d;
      mem_addr_q <= mem_addr_d;
      req_q      <= (state_d == S_REQ) || (state_d == S_READ);
      busy_q     <= (state_d != S_IDLE);
      valid_q    <= (state_d == S_DONE);
    end
  end

  // The assembled line stays visible after the fill until bytes are overwritten.
  refill_line_buffer u_line_buf (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .we_i    (cap_en_c),
    .clr_i   (1'b0),
    .slot_i  (recv_q),
    .din_i   (bus.ramDataIn),
    .line_o  (bus.memDataOut)
  );

  assign bus.reqOut       = req_q;
  assign bus.ramAddrOut   = ram_addr_q;
  assign bus.memDataValid = valid_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.busyOut      = busy_q;

`ifdef ICACHE_REFILL_STATS_EN
  logic [STAT_W-1:0] refill_cnt_q, stall_cnt_q;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      refill_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      refill_cnt_q <= refill_cnt_q + STAT_W'(valid_q);
      stall_cnt_q  <= stall_cnt_q + STAT_W'(busy_q);
    end
  end

  assign bus.refillCountOut = refill_cnt_q;
  assign bus.stallCycleOut  = stall_cnt_q;
`endif

endmodule
